// File: rtl/spu_writeback_tracker.sv
// Writeback end of the dual-pipe SPU: registers both final-stage results onto the RF write ports,
// resolves same-RT collisions, and keeps the per-register pending/countdown scoreboard.
module spu_writeback_tracker #(
    parameter int unsigned NUM_REGS = 128,
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned LAT_W    = 3,
    localparam int unsigned RT_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid1,
    input  logic              issue_valid2,
    input  logic [RT_W-1:0]   issue_rt1,
    input  logic [RT_W-1:0]   issue_rt2,
    input  logic [LAT_W-1:0]  issue_latency1,
    input  logic [LAT_W-1:0]  issue_latency2,
    input  logic              wb_en1,
    input  logic              wb_en2,
    input  logic [DATA_W-1:0] wb_result1,
    input  logic [DATA_W-1:0] wb_result2,
    input  logic [RT_W-1:0]   wb_rt1,
    input  logic [RT_W-1:0]   wb_rt2,
    input  logic [2:0]        wb_unit1,
    input  logic [2:0]        wb_unit2,
    output logic              rf_we1,
    output logic              rf_we2,
    output logic [RT_W-1:0]   rf_waddr1,
    output logic [RT_W-1:0]   rf_waddr2,
    output logic [DATA_W-1:0] rf_wdata1,
    output logic [DATA_W-1:0] rf_wdata2,
    output logic [2:0]        rf_unit1,
    output logic [2:0]        rf_unit2,
    input  logic [RT_W-1:0]   query_ra,
    input  logic [RT_W-1:0]   query_rb,
    input  logic [RT_W-1:0]   query_rc,
    output logic              busy_ra,
    output logic              busy_rb,
    output logic              busy_rc,
    output logic              wb_collision,
    output logic              err_spurious,
    output logic              err_overdue,
    output logic [7:0]        inflight_count
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [LAT_W-1:0]    cnt_q [NUM_REGS];
    logic [LAT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] iss1_hit, iss2_hit, wb_hit, spurious_vec, overdue_vec;
    logic                collision, wb1_live;
    logic [7:0]          inflight_d;

    logic              rf_we1_q, rf_we2_q, collision_q, err_spurious_q, err_overdue_q;
    logic [RT_W-1:0]   rf_waddr1_q, rf_waddr2_q;
    logic [DATA_W-1:0] rf_wdata1_q, rf_wdata2_q;
    logic [2:0]        rf_unit1_q, rf_unit2_q;
    logic [7:0]        inflight_q;

    // Pipe 2 holds the younger instruction, so it wins a same-RT writeback.
    assign collision = wb_en1 && wb_en2 && (wb_rt1 == wb_rt2);
    assign wb1_live  = wb_en1 && !collision;

    always_comb begin
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        iss1_hit     = '0;
        iss2_hit     = '0;
        wb_hit       = '0;
        spurious_vec = '0;
        overdue_vec  = '0;
        inflight_d   = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            iss1_hit[r] = issue_valid1 && (issue_rt1 == RT_W'(r));
            iss2_hit[r] = issue_valid2 && (issue_rt2 == RT_W'(r));
            wb_hit[r]   = (wb1_live && (wb_rt1 == RT_W'(r))) || (wb_en2 && (wb_rt2 == RT_W'(r)));
            if (iss2_hit[r]) begin
                pending_d[r] = 1'b1;
                cnt_d[r]     = issue_latency2;
            end else if (iss1_hit[r]) begin
                pending_d[r] = 1'b1;
                cnt_d[r]     = issue_latency1;
            end else if (wb_hit[r]) begin
                pending_d[r] = 1'b0;
                cnt_d[r]     = '0;
            end else if (pending_q[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
            spurious_vec[r] = wb_hit[r] && !pending_q[r] && !iss1_hit[r] && !iss2_hit[r];
            overdue_vec[r]  = pending_q[r] && (cnt_q[r] == '0) && !wb_hit[r];
            inflight_d      = inflight_d + 8'(pending_d[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q      <= '0;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            rf_we1_q       <= 1'b0;
            rf_we2_q       <= 1'b0;
            rf_waddr1_q    <= '0;
            rf_waddr2_q    <= '0;
            rf_wdata1_q    <= '0;
            rf_wdata2_q    <= '0;
            rf_unit1_q     <= '0;
            rf_unit2_q     <= '0;
            collision_q    <= 1'b0;
            err_spurious_q <= 1'b0;
            err_overdue_q  <= 1'b0;
            inflight_q     <= '0;
        end else begin
            pending_q      <= pending_d;
            cnt_q          <= cnt_d;
            rf_we1_q       <= wb1_live;
            rf_we2_q       <= wb_en2;
            rf_waddr1_q    <= wb_rt1;
            rf_waddr2_q    <= wb_rt2;
            rf_wdata1_q    <= wb_result1;
            rf_wdata2_q    <= wb_result2;
            rf_unit1_q     <= wb_unit1;
            rf_unit2_q     <= wb_unit2;
            collision_q    <= collision;
            err_spurious_q <= err_spurious_q | (|spurious_vec);
            err_overdue_q  <= err_overdue_q | (|overdue_vec);
            inflight_q     <= inflight_d;
        end
    end

    assign rf_we1         = rf_we1_q;
    assign rf_we2         = rf_we2_q;
    assign rf_waddr1      = rf_waddr1_q;
    assign rf_waddr2      = rf_waddr2_q;
    assign rf_wdata1      = rf_wdata1_q;
    assign rf_wdata2      = rf_wdata2_q;
    assign rf_unit1       = rf_unit1_q;
    assign rf_unit2       = rf_unit2_q;
    assign wb_collision   = collision_q;
    assign err_spurious   = err_spurious_q;
    assign err_overdue    = err_overdue_q;
    assign inflight_count = inflight_q;

    // No bypass: busy reflects the scoreboard as of the last edge.
    assign busy_ra = pending_q[query_ra];
    assign busy_rb = pending_q[query_rb];
    assign busy_rc = pending_q[query_rc];

endmodule

// File: tb/tb_spu_writeback_tracker.sv
// Directed bench: expected RF writes are queued at stimulus time and popped by a negedge monitor;
// scoreboard status (busy, errors, inflight) is checked against hand-computed values.
module tb_spu_writeback_tracker;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         issue_valid1 = 0, issue_valid2 = 0;
    logic [6:0]   issue_rt1 = 0, issue_rt2 = 0;
    logic [2:0]   issue_latency1 = 0, issue_latency2 = 0;
    logic         wb_en1 = 0, wb_en2 = 0;
    logic [127:0] wb_result1 = 0, wb_result2 = 0;
    logic [6:0]   wb_rt1 = 0, wb_rt2 = 0;
    logic [2:0]   wb_unit1 = 0, wb_unit2 = 0;
    logic         rf_we1, rf_we2;
    logic [6:0]   rf_waddr1, rf_waddr2;
    logic [127:0] rf_wdata1, rf_wdata2;
    logic [2:0]   rf_unit1, rf_unit2;
    logic [6:0]   query_ra = 5, query_rb = 9, query_rc = 20;
    logic         busy_ra, busy_rb, busy_rc;
    logic         wb_collision, err_spurious, err_overdue;
    logic [7:0]   inflight_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic         we1, we2, col;
        logic [6:0]   a1, a2;
        logic [127:0] d1, d2;
        logic [2:0]   u1, u2;
    } wr_t;
    wr_t exp_q[$];

    spu_writeback_tracker dut (
        .clk(clk), .reset(reset),
        .issue_valid1(issue_valid1), .issue_valid2(issue_valid2),
        .issue_rt1(issue_rt1), .issue_rt2(issue_rt2),
        .issue_latency1(issue_latency1), .issue_latency2(issue_latency2),
        .wb_en1(wb_en1), .wb_en2(wb_en2),
        .wb_result1(wb_result1), .wb_result2(wb_result2),
        .wb_rt1(wb_rt1), .wb_rt2(wb_rt2),
        .wb_unit1(wb_unit1), .wb_unit2(wb_unit2),
        .rf_we1(rf_we1), .rf_we2(rf_we2),
        .rf_waddr1(rf_waddr1), .rf_waddr2(rf_waddr2),
        .rf_wdata1(rf_wdata1), .rf_wdata2(rf_wdata2),
        .rf_unit1(rf_unit1), .rf_unit2(rf_unit2),
        .query_ra(query_ra), .query_rb(query_rb), .query_rc(query_rc),
        .busy_ra(busy_ra), .busy_rb(busy_rb), .busy_rc(busy_rc),
        .wb_collision(wb_collision), .err_spurious(err_spurious), .err_overdue(err_overdue),
        .inflight_count(inflight_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid1 = 0; issue_valid2 = 0;
        wb_en1 = 0; wb_en2 = 0;
    endtask

    task automatic push_wr(input logic we1, input logic we2, input logic col,
                           input logic [6:0] a1, input logic [6:0] a2,
                           input logic [127:0] d1, input logic [127:0] d2,
                           input logic [2:0] u1, input logic [2:0] u2);
        wr_t e;
        e.we1 = we1; e.we2 = we2; e.col = col;
        e.a1 = a1; e.a2 = a2; e.d1 = d1; e.d2 = d2; e.u1 = u1; e.u2 = u2;
        exp_q.push_back(e);
    endtask

    // Monitor: any write or collision pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && (rf_we1 || rf_we2 || wb_collision)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: we1=%0b we2=%0b col=%0b expected none",
                         rf_we1, rf_we2, wb_collision);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rf_we1", rf_we1, e.we1);
                chk("rf_we2", rf_we2, e.we2);
                chk("wb_collision", wb_collision, e.col);
                if (e.we1) begin
                    chk("rf_waddr1", rf_waddr1, e.a1);
                    chk("rf_wdata1", rf_wdata1, e.d1);
                    chk("rf_unit1", rf_unit1, e.u1);
                end
                if (e.we2) begin
                    chk("rf_waddr2", rf_waddr2, e.a2);
                    chk("rf_wdata2", rf_wdata2, e.d2);
                    chk("rf_unit2", rf_unit2, e.u2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        #23;
        chk("rst_inflight", inflight_count, 0);
        chk("rst_we1", rf_we1, 0);
        reset = 1'b1;
        step();
        step();
        chk("idle_we1", rf_we1, 0);
        chk("idle_we2", rf_we2, 0);
        chk("idle_col", wb_collision, 0);
        chk("idle_err_spurious", err_spurious, 0);
        chk("idle_err_overdue", err_overdue, 0);
        chk("idle_inflight", inflight_count, 0);
        chk("idle_busy", {busy_ra, busy_rb, busy_rc}, 0);

        // Issue rt5 lat4, write back three cycles later
        issue_valid1 = 1; issue_rt1 = 5; issue_latency1 = 4;
        step();
        clear_inputs();
        chk("iss5_busy", busy_ra, 1);
        chk("iss5_inflight", inflight_count, 1);
        step();
        step();
        wb_en1 = 1; wb_rt1 = 5; wb_result1 = 128'hDEAD; wb_unit1 = 3;
        push_wr(1, 0, 0, 5, 0, 128'hDEAD, 0, 3, 0);
        step();
        clear_inputs();
        chk("wb5_busy", busy_ra, 0);
        chk("wb5_inflight", inflight_count, 0);
        chk("wb5_err_spurious", err_spurious, 0);
        chk("wb5_err_overdue", err_overdue, 0);

        // Same-RT collision on rt9 (pending, so not spurious)
        issue_valid1 = 1; issue_rt1 = 9; issue_latency1 = 3;
        step();
        clear_inputs();
        chk("iss9_busy", busy_rb, 1);
        wb_en1 = 1; wb_rt1 = 9; wb_result1 = 128'hAAAA_0001; wb_unit1 = 1;
        wb_en2 = 1; wb_rt2 = 9; wb_result2 = 128'hBBBB_0002; wb_unit2 = 2;
        push_wr(0, 1, 1, 0, 9, 0, 128'hBBBB_0002, 0, 2);
        step();
        clear_inputs();
        chk("col_busy", busy_rb, 0);
        chk("col_err_spurious", err_spurious, 0);
        step();
        chk("col_one_pulse", wb_collision, 0);

        // Spurious writeback to rt20
        wb_en2 = 1; wb_rt2 = 20; wb_result2 = 128'hC0FFEE; wb_unit2 = 5;
        push_wr(0, 1, 0, 0, 20, 0, 128'hC0FFEE, 0, 5);
        step();
        clear_inputs();
        chk("spur_set", err_spurious, 1);
        step();
        step();
        chk("spur_sticky", err_spurious, 1);

        // Overdue: rt7 lat1 never written back
        query_ra = 7;
        issue_valid1 = 1; issue_rt1 = 7; issue_latency1 = 1;
        step();
        clear_inputs();
        step();
        chk("ovd_not_yet", err_overdue, 0);
        step();
        chk("ovd_set", err_overdue, 1);
        chk("ovd_busy", busy_ra, 1);

        // Mid-flight async reset with three pending
        issue_valid1 = 1; issue_rt1 = 30; issue_latency1 = 6;
        issue_valid2 = 1; issue_rt2 = 31; issue_latency2 = 6;
        step();
        clear_inputs();
        chk("pre_rst_inflight", inflight_count, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_inflight", inflight_count, 0);
        chk("async_busy", busy_ra, 0);
        chk("async_err_spurious", err_spurious, 0);
        chk("async_err_overdue", err_overdue, 0);
        step();
        reset = 1'b1;
        step();

        // Same-cycle issue and writeback on rt12: issue wins
        query_rc = 12;
        issue_valid2 = 1; issue_rt2 = 12; issue_latency2 = 5;
        step();
        clear_inputs();
        issue_valid1 = 1; issue_rt1 = 12; issue_latency1 = 2;
        wb_en1 = 1; wb_rt1 = 12; wb_result1 = 128'h1234_5678; wb_unit1 = 4;
        push_wr(1, 0, 0, 12, 0, 128'h1234_5678, 0, 4, 0);
        step();
        clear_inputs();
        chk("iw_busy", busy_rc, 1);
        chk("iw_inflight", inflight_count, 1);
        chk("iw_err_spurious", err_spurious, 0);
        step();
        step();
        chk("iw_cnt_not_zero_yet", err_overdue, 0);
        step();
        chk("iw_cnt2_overdue", err_overdue, 1);

        step();
        step();
        chk("queue_drained", 128'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
